alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  op request valid.
REQ-005 in_ready  output  1  stage can accept request this cycle.
REQ-006 in_aluop  input  tiny8_aluop  operation (alu_add, alu_sub, alu_dec, alu_mul).
REQ-007 in_dst, in_srca, in_srcb  input  3 each  destination, source A, source B register indices.
REQ-008 in_imm_en  input  1  B operand taken from in_imm instead of register file.
REQ-009 in_imm  input  tiny8_word (8)  immediate B operand.
REQ-010 alu_aluop  output  tiny8_aluop  operation driven to the ALU.
REQ-011 alu_a, alu_b  output  8 each  operands driven to the ALU.
REQ-012 alu_f  input  8  combinational ALU result.
REQ-013 wb_valid  output  1  writeback-report strobe, one cycle per op.
REQ-014 wb_dst  output  3  register written.
REQ-015 wb_data  output  8  value written.
REQ-016 dbg_idx  input  3; dbg_data  output  8  asynchronous register file read port for the bench.

Function
REQ-017 The register file SHALL hold 8 x 8-bit registers; r0 reads 0 always, and writes to r0 are discarded.
REQ-018 A request SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-019 At acceptance, A = reg[in_srca] and B = in_imm_en ? in_imm : reg[in_srcb] SHALL be latched with aluop and dst into the EX register, and EX valid SHALL be set.
REQ-020 In the cycle after acceptance, alu_aluop/alu_a/alu_b SHALL be driven from the EX register; when EX is not valid they hold their last values.
REQ-021 At the end of that EX cycle, reg[dst] <= alu_f (unless dst=0), and wb_valid/wb_dst/wb_data <= 1/dst/alu_f.
REQ-022 Latency: accepted at edge N, register written at edge N+1, wb_valid high for exactly the cycle after edge N+1.
REQ-023 Throughput SHALL be one op per cycle absent hazards; wb_valid de-asserts in any cycle that follows a non-valid EX cycle.
REQ-024 Hazard definition: EX valid, EX dst != 0, and the incoming request reads that dst (srca, or srcb when in_imm_en=0).
REQ-025 Reads of a register written at the same edge SHALL return the new value (write-before-read through the file).
REQ-026 Simultaneous writeback of rX and request reading rX resolved per Configuration.
REQ-027 The ALU SHALL be treated as purely combinational; alu_mul uses only b[3:0], and the stage SHALL NOT mask B.
REQ-028 All arithmetic SHALL wrap modulo 256; the stage SHALL NOT generate flags.

Reset
REQ-029 While rst is high at a rising edge: all registers <= 0, EX valid <= 0, EX aluop <= alu_add, EX A/B/dst <= 0, wb_valid <= 0, wb_dst <= 0, wb_data <= 0.
REQ-030 in_ready SHALL be 0 while rst is high; a request presented during reset SHALL NOT be accepted.
REQ-031 An op in EX when reset asserts SHALL be discarded, with no register write and no wb_valid.

Configuration
REQ-032 Macro ALU_ISSUE_BYPASS_EN defined: on a hazard, the hazarded operand is taken from alu_f, and in_ready = !rst (never stalls).
REQ-033 ALU_ISSUE_BYPASS_EN undefined: in_ready = !rst && !hazard, giving a one-cycle stall, after which the value is read from the file.

Verification
REQ-034 Reset test: after reset, dbg_data=0 for all idx, wb_valid=0, in_ready=1; a request held during rst is never written back.
REQ-035 Load/add: add r1=r0+imm 5, then add r2=r0+imm 7 non-dependent; later add r3=r1+r2 -> wb_data 12 to r3 two edges after its acceptance.
REQ-036 Back-to-back dependency: r1=5, then sub r4=r1-imm 3 issued the cycle right after -> with bypass no stall and wb 2; without bypass in_ready low one cycle, wb 2 one cycle later.
REQ-037 Wrap/mul/dec: r1=0 then dec r5=r1 -> 0xFF; r1=0x23 and mul r6=r1*imm 0xF3 -> 0x23*3 = 0x69.
REQ-038 r0 write: add r0=r0+imm 9 -> wb_valid=1, wb_dst=0, wb_data=9, dbg_data[0] stays 0, and a following read of r0 raises no hazard.
REQ-039 Reset mid-op: assert rst in the EX cycle of add r7=imm 0x42 -> no wb_valid, r7 stays 0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// tiny8 shared types: ALU opcodes, data word, EX-stage bundle.
// Used by alu_issue and anything driving or observing it.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    alu_add = 2'd0,
    alu_sub = 2'd1,
    alu_dec = 2'd2,
    alu_mul = 2'd3
  } tiny8_aluop;

  typedef logic [7:0] tiny8_word;

  typedef struct packed {
    logic       valid;
    tiny8_aluop op;
    logic [2:0] dst;
    tiny8_word  a;
    tiny8_word  b;
  } id_ex_t;

endpackage

// File: rtl/alu_issue.sv
// tiny8 issue stage: 8x8 register file, EX register, writeback report.
// Define ALU_ISSUE_BYPASS_EN to forward alu_f on RAW hazards instead of stalling.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  tiny8_aluop in_aluop,
  input  logic [2:0] in_dst,
  input  logic [2:0] in_srca,
  input  logic [2:0] in_srcb,
  input  logic       in_imm_en,
  input  tiny8_word  in_imm,
  output tiny8_aluop alu_aluop,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_f,
  output logic       wb_valid,
  output logic [2:0] wb_dst,
  output logic [7:0] wb_data,
  input  logic [2:0] dbg_idx,
  output logic [7:0] dbg_data
);

  tiny8_word rf [8];
  id_ex_t    ex;

  logic      ex_wr;
  logic      haz_a;
  logic      haz_b;
  logic      hazard;
  logic      accept;
  tiny8_word rd_a;
  tiny8_word rd_b;
  tiny8_word op_a;
  tiny8_word op_b;

  assign rd_a = (in_srca == 3'd0) ? 8'h00 : rf[in_srca];
  assign rd_b = (in_srcb == 3'd0) ? 8'h00 : rf[in_srcb];

  assign ex_wr  = ex.valid && (ex.dst != 3'd0);
  assign haz_a  = ex_wr && (in_srca == ex.dst);
  assign haz_b  = ex_wr && !in_imm_en && (in_srcb == ex.dst);
  assign hazard = haz_a || haz_b;

`ifdef ALU_ISSUE_BYPASS_EN
  // The value landing in the file this edge is alu_f; take it directly.
  always_comb begin
    op_a = haz_a ? alu_f : rd_a;
    op_b = in_imm_en ? in_imm : (haz_b ? alu_f : rd_b);
  end

  assign in_ready = !rst;
`else
  // Hazards stall one cycle, after which the file already holds the result.
  always_comb begin
    op_a = rd_a;
    op_b = in_imm_en ? in_imm : rd_b;
  end

  assign in_ready = !rst && !hazard;
`endif

  assign accept = in_valid && in_ready;

  assign alu_aluop = ex.op;
  assign alu_a     = ex.a;
  assign alu_b     = ex.b;

  assign dbg_data = (dbg_idx == 3'd0) ? 8'h00 : rf[dbg_idx];

  // Register file write from the EX result; r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= 8'h00;
      end
    end else if (ex_wr) begin
      rf[ex.dst] <= alu_f;
    end
  end

  // EX register: operands hold between ops, only valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex.valid <= 1'b0;
      ex.op    <= alu_add;
      ex.dst   <= 3'd0;
      ex.a     <= 8'h00;
      ex.b     <= 8'h00;
    end else begin
      ex.valid <= accept;
      if (accept) begin
        ex.op  <= in_aluop;
        ex.dst <= in_dst;
        ex.a   <= op_a;
        ex.b   <= op_b;
      end
    end
  end

  // Writeback report, one strobe per completed EX cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_dst   <= 3'd0;
      wb_data  <= 8'h00;
    end else begin
      wb_valid <= ex.valid;
      if (ex.valid) begin
        wb_dst  <= ex.dst;
        wb_data <= alu_f;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural ALU.
// Expected writebacks queued at acceptance, popped on wb_valid.
module tb_alu_issue;
  import alu_issue_pkg::*;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  tiny8_aluop in_aluop;
  logic [2:0] in_dst;
  logic [2:0] in_srca;
  logic [2:0] in_srcb;
  logic       in_imm_en;
  tiny8_word  in_imm;
  tiny8_aluop alu_aluop;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_f;
  logic       wb_valid;
  logic [2:0] wb_dst;
  logic [7:0] wb_data;
  logic [2:0] dbg_idx;
  logic [7:0] dbg_data;

  alu_issue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_aluop  (in_aluop),
    .in_dst    (in_dst),
    .in_srca   (in_srca),
    .in_srcb   (in_srcb),
    .in_imm_en (in_imm_en),
    .in_imm    (in_imm),
    .alu_aluop (alu_aluop),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .wb_valid  (wb_valid),
    .wb_dst    (wb_dst),
    .wb_data   (wb_data),
    .dbg_idx   (dbg_idx),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(
    input tiny8_aluop op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    case (op)
      alu_sub: r = a - b;
      alu_dec: r = a - 8'd1;
      alu_mul: r = a * {4'd0, b[3:0]};
      default: r = a + b;
    endcase
    return r;
  endfunction

  always_comb alu_f = alu_model(alu_aluop, alu_a, alu_b);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0] dst;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb [$];
  exp_t       e;
  logic [7:0] mreg [8];
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb.size() == 0) begin
        chk("wb_spurious", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wb_dst", wb_dst, e.dst);
        chk("wb_data", wb_data, e.data);
        chk("wb_lat", cyc, e.cyc + 2);
      end
    end
  end

  task automatic issue(
    input  tiny8_aluop op,
    input  logic [2:0] dst,
    input  logic [2:0] sa,
    input  logic [2:0] sbi,
    input  logic       ie,
    input  logic [7:0] imm,
    output int         stalls
  );
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] f;
    in_valid  = 1'b1;
    in_aluop  = op;
    in_dst    = dst;
    in_srca   = sa;
    in_srcb   = sbi;
    in_imm_en = ie;
    in_imm    = imm;
    stalls    = 0;
    #1;
    while (!in_ready && stalls < 4) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    a = mreg[sa];
    b = ie ? imm : mreg[sbi];
    f = alu_model(op, a, b);
    if (dst != 3'd0) mreg[dst] = f;
    sb.push_back('{dst, f, cyc});
    @(posedge clk);
    #1;
    chk("alu_op", alu_aluop, op);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_idx = i[2:0];
      #1;
      chk(tag, dbg_data, mreg[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int         st;
    logic [2:0] prev_dst;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       ie;
    tiny8_aluop op;
    int         hz;

    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    dbg_idx   = 3'd0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_aluop  = alu_add;
    in_dst    = 3'd7;
    in_srca   = 3'd0;
    in_srcb   = 3'd0;
    in_imm_en = 1'b1;
    in_imm    = 8'h55;

    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", in_ready, 0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_aluop, alu_add);
    check_rf("rst_rf");
    idle(3);
    check_rf("rst_rf_after");

    @(negedge clk);
    issue(alu_add, 3'd1, 3'd0, 3'd0, 1'b1, 8'd5, st);
    issue(alu_add, 3'd2, 3'd0, 3'd0, 1'b1, 8'd7, st);
    idle(2);
    issue(alu_add, 3'd3, 3'd1, 3'd2, 1'b0, 8'd0, st);
    chk("add_nostall", st, 0);
    idle(3);
    chk("r3_is_12", mreg[3], 8'd12);

    issue(alu_add, 3'd1, 3'd0, 3'd0, 1'b1, 8'd5, st);
    issue(alu_sub, 3'd4, 3'd1, 3'd0, 1'b1, 8'd3, st);
    chk("b2b_stall", st, EXP_STALL);
    issue(alu_add, 3'd1, 3'd0, 3'd0, 1'b1, 8'd0, st);
    issue(alu_dec, 3'd5, 3'd1, 3'd0, 1'b1, 8'd0, st);
    chk("dec_stall", st, EXP_STALL);
    issue(alu_add, 3'd1, 3'd0, 3'd0, 1'b1, 8'h23, st);
    issue(alu_mul, 3'd6, 3'd1, 3'd0, 1'b1, 8'hF3, st);
    issue(alu_add, 3'd0, 3'd0, 3'd0, 1'b1, 8'd9, st);
    issue(alu_add, 3'd2, 3'd0, 3'd0, 1'b0, 8'd0, st);
    chk("r0_nohaz", st, 0);
    idle(3);
    chk("m_r4", mreg[4], 8'h02);
    chk("m_r5", mreg[5], 8'hFF);
    chk("m_r6", mreg[6], 8'h69);
    check_rf("dir_rf");

    prev_dst = 3'd0;
    for (int n = 0; n < 60; n++) begin
      op = tiny8_aluop'($urandom_range(0, 3));
      rd = 3'($urandom_range(0, 7));
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      ie = 1'($urandom_range(0, 1));
      hz = (prev_dst != 3'd0) &&
           ((ra == prev_dst) || (!ie && rb == prev_dst)) ? 1 : 0;
      issue(op, rd, ra, rb, ie, 8'($urandom_range(0, 255)), st);
      chk("rnd_stall", st, hz * EXP_STALL);
      prev_dst = rd;
    end
    idle(3);
    check_rf("rnd_rf");
    chk("sb_drained", sb.size(), 0);

    in_valid  = 1'b1;
    in_aluop  = alu_add;
    in_dst    = 3'd7;
    in_srca   = 3'd0;
    in_srcb   = 3'd0;
    in_imm_en = 1'b1;
    in_imm    = 8'h42;
    #1;
    chk("midrst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_ready_low", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    #1;
    chk("midrst_wb", wb_valid, 0);
    idle(3);
    dbg_idx = 3'd7;
    #1;
    chk("midrst_r7", dbg_data, 0);
    check_rf("midrst_rf");

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
